// File: rtl/fast_square_tx_stepper.sv
// Stepped-frequency quadrature square-wave transmitter that follows a remote
// sweep controller's arm line and frequency-step strobe.
module fast_square_tx_stepper #(
   parameter int unsigned        NUM_FREQ_STEPS = 32,
   parameter int unsigned        STEP_W         = 5,
   parameter logic [31:0]        PHASE_INC_BASE = 32'h0100_0000,
   parameter logic [31:0]        PHASE_INC_STEP = 32'h0008_0000,
   parameter logic signed [15:0] AMP            = 16'sd8192,
   parameter int unsigned        GUARD_TICKS    = 64
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     ext_arm,
   input  logic                     ext_freq_step,
   output logic signed [15:0]       i_out,
   output logic signed [15:0]       q_out,
   output logic                     tx_active,
   output logic [STEP_W-1:0]        step_index,
   output logic                     step_overrun
);

   localparam int unsigned GCNT_W = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
   localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_TICKS - 1);
   localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_FREQ_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_TONE  = 2'd2
   } state_t;

   function automatic logic signed [15:0] square_level(input logic negative);
      return negative ? -AMP : AMP;
   endfunction

   logic arm_meta_q, arm_meta_d;
   logic arm_sync_q, arm_sync_d;
   logic step_meta_q, step_meta_d;
   logic step_sync_q, step_sync_d;
   logic step_prev_q, step_prev_d;
   logic step_edge_q, step_edge_d;

   state_t              state_q, state_d;
   logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
   logic [STEP_W-1:0]   idx_q, idx_d;
   logic [31:0]         phase_q, phase_d;
   logic [31:0]         inc_q, inc_d;
   logic                ovr_q, ovr_d;
   logic signed [15:0]  i_q, i_d;
   logic signed [15:0]  q_q, q_d;
   logic                act_q, act_d;
   logic                armed;

   // Input conditioning: both remote lines are asynchronous to clk64.
   always_comb begin
      arm_meta_d  = ext_arm;
      arm_sync_d  = arm_meta_q;
      step_meta_d = ext_freq_step;
      step_sync_d = step_meta_q;
      step_prev_d = step_sync_q;
      step_edge_d = step_sync_q & ~step_prev_q;
   end

   assign armed = arm_sync_q & enable;

   // Sweep controller; a disarm takes priority over any pending step.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      inc_d   = inc_q;
      ovr_d   = ovr_q;

      if (!armed) begin
         state_d = ST_IDLE;
         gcnt_d  = '0;
         idx_d   = '0;
         phase_d = '0;
         inc_d   = PHASE_INC_BASE;
         ovr_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_GUARD;
               gcnt_d  = '0;
               phase_d = '0;
            end
            ST_GUARD: begin
               phase_d = '0;
               if (step_edge_q) begin
                  ovr_d = 1'b1;
               end
               if (gcnt_q == GUARD_LAST) begin
                  state_d = ST_TONE;
                  gcnt_d  = '0;
               end else begin
                  gcnt_d = gcnt_q + GCNT_W'(1);
               end
            end
            ST_TONE: begin
               if (step_edge_q) begin
                  state_d = ST_GUARD;
                  gcnt_d  = '0;
                  phase_d = '0;
                  if (idx_q == LAST_STEP) begin
                     idx_d = '0;
                     inc_d = PHASE_INC_BASE;
                  end else begin
                     idx_d = idx_q + STEP_W'(1);
                     inc_d = inc_q + PHASE_INC_STEP;
                  end
               end else begin
                  phase_d = phase_q + inc_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Two phase MSBs give I and a quarter-period-shifted Q without any multiplier.
   always_comb begin
      i_d   = 16'sd0;
      q_d   = 16'sd0;
      act_d = 1'b0;
      if (state_q == ST_TONE) begin
         i_d   = square_level(phase_q[31]);
         q_d   = square_level(phase_q[31] ^ phase_q[30]);
         act_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         arm_meta_q  <= 1'b0;
         arm_sync_q  <= 1'b0;
         step_meta_q <= 1'b0;
         step_sync_q <= 1'b0;
         step_prev_q <= 1'b0;
         step_edge_q <= 1'b0;
         state_q     <= ST_IDLE;
         gcnt_q      <= '0;
         idx_q       <= '0;
         phase_q     <= '0;
         inc_q       <= PHASE_INC_BASE;
         ovr_q       <= 1'b0;
         i_q         <= 16'sd0;
         q_q         <= 16'sd0;
         act_q       <= 1'b0;
      end else begin
         arm_meta_q  <= arm_meta_d;
         arm_sync_q  <= arm_sync_d;
         step_meta_q <= step_meta_d;
         step_sync_q <= step_sync_d;
         step_prev_q <= step_prev_d;
         step_edge_q <= step_edge_d;
         state_q     <= state_d;
         gcnt_q      <= gcnt_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         inc_q       <= inc_d;
         ovr_q       <= ovr_d;
         i_q         <= i_d;
         q_q         <= q_d;
         act_q       <= act_d;
      end
   end

   assign i_out        = i_q;
   assign q_out        = q_q;
   assign tx_active    = act_q;
   assign step_index   = idx_q;
   assign step_overrun = ovr_q;

endmodule
